// File: rtl/codec_ctrl_pkg.sv
// Shared types and helpers for the codec stage sequencer: FSM state encoding
// and the quality clamp applied once per block.
package codec_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_NEXT   = 3'd4,
    S_FIN    = 3'd5
  } seq_state_t;

  localparam int unsigned QMIN = 1;
  localparam int unsigned QMAX = 100;

  function automatic int unsigned q_clamp(input int unsigned q);
    if (q < QMIN) return QMIN;
    if (q > QMAX) return QMAX;
    return q;
  endfunction

endpackage

// File: rtl/codec_stage_seq_if.sv
// Block handshake, quality and stage control bundle of the stage sequencer.
// STAGE_BYPASS_EN adds the per-block bypass_mask.
interface codec_stage_seq_if #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned QW         = 7
);
  localparam int unsigned SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [QW-1:0]         q_in;
  logic [QW-1:0]         q_out;
  logic [NUM_STAGES-1:0] stg_clr;
  logic [NUM_STAGES-1:0] stg_en;
  logic [NUM_STAGES-1:0] stg_done;
  logic [SW-1:0]         cur_stage;
  logic                  out_valid;
  logic                  out_ready;
  logic                  err;
  logic                  busy;
`ifdef STAGE_BYPASS_EN
  logic [NUM_STAGES-1:0] bypass_mask;
`endif

  // master: the sequencer; slave: block source/sink and stage modules
  modport master (
    input  in_valid, q_in, stg_done, out_ready,
`ifdef STAGE_BYPASS_EN
    input  bypass_mask,
`endif
    output in_ready, q_out, stg_clr, stg_en, cur_stage, out_valid, err, busy
  );

  modport slave (
    output in_valid, q_in, stg_done, out_ready,
`ifdef STAGE_BYPASS_EN
    output bypass_mask,
`endif
    input  in_ready, q_out, stg_clr, stg_en, cur_stage, out_valid, err, busy
  );

endinterface

// File: rtl/stage_timer.sv
// Per-stage WAIT timer: load clears, inc counts; expire_o is high while the
// count sits at TIMEOUT_CYC-1.
module stage_timer #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic inc_i,
  output logic expire_o
);
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          expire_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)     cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + TW'(1);
  end

  // expire is registered from the next count so it lines up with cnt_q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= (cnt_d == LAST);
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/codec_stage_seq.sv
// Sequences one block through a chain of NUM_STAGES stages (clear, start,
// wait for done with timeout). Optional STAGE_BYPASS_EN skips masked stages.
module codec_stage_seq
  import codec_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned QW          = 7
) (
  input logic               clk,
  input logic               rst,
  codec_stage_seq_if.master bus
);
  localparam int unsigned SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  seq_state_t            state_q, state_d;
  logic [SW-1:0]         stage_q, stage_d;
  logic [QW-1:0]         q_q, q_d;
  logic                  err_q, err_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;
  logic                  out_valid_q, out_valid_d;
  logic [NUM_STAGES-1:0] clr_q, clr_d, en_q, en_d;
  logic [NUM_STAGES-1:0] skip_mask;
  logic                  timer_load, timer_inc, timer_expire;
  logic                  nxt_found;
  logic [SW-1:0]         nxt_idx;

`ifdef STAGE_BYPASS_EN
  logic [NUM_STAGES-1:0] mask_q, mask_d;
  assign skip_mask = mask_q;
`else
  assign skip_mask = '0;
`endif

  stage_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (timer_load),
    .inc_i    (timer_inc),
    .expire_o (timer_expire)
  );

  // lowest non-skipped stage above the current one
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
      if (i > int'(stage_q) && !skip_mask[i]) begin
        nxt_found = 1'b1;
        nxt_idx   = SW'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    q_d        = q_q;
    err_d      = err_q;
    timer_load = 1'b0;
    timer_inc  = 1'b0;
`ifdef STAGE_BYPASS_EN
    mask_d     = mask_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          q_d     = QW'(q_clamp(32'(bus.q_in)));
          stage_d = '0;
          err_d   = 1'b0;
`ifdef STAGE_BYPASS_EN
          mask_d  = bus.bypass_mask;
          state_d = bus.bypass_mask[0] ? S_NEXT : S_CLR;
`else
          state_d = S_CLR;
`endif
        end
      end
      S_CLR:    state_d = S_LAUNCH;
      S_LAUNCH: begin
        timer_load = 1'b1;
        state_d    = S_WAIT;
      end
      // done beats a simultaneous timer expiry
      S_WAIT: begin
        if (bus.stg_done[stage_q]) begin
          state_d = S_NEXT;
        end else if (timer_expire) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          timer_inc = 1'b1;
        end
      end
      S_NEXT: begin
        if (nxt_found) begin
          stage_d = nxt_idx;
          state_d = S_CLR;
        end else begin
          state_d = S_FIN;
        end
      end
      S_FIN:   if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    out_valid_d = (state_d == S_FIN);
    clr_d       = (state_d == S_CLR)    ? (NUM_STAGES'(1) << stage_d) : '0;
    en_d        = (state_d == S_LAUNCH) ? (NUM_STAGES'(1) << stage_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      stage_q     <= '0;
      q_q         <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      clr_q       <= '0;
      en_q        <= '0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      q_q         <= q_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      clr_q       <= clr_d;
      en_q        <= en_d;
    end
  end

`ifdef STAGE_BYPASS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mask_q <= '0;
    else     mask_q <= mask_d;
  end
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.q_out     = q_q;
  assign bus.stg_clr   = clr_q;
  assign bus.stg_en    = en_q;
  assign bus.cur_stage = stage_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_codec_stage_seq.sv
// Bench for codec_stage_seq: stub stages with programmable done delay,
// table of blocks with hand-computed latency/quality/error, plus reset sequences.
`timescale 1ns/1ps
module tb_codec_stage_seq;
  import codec_ctrl_pkg::*;

  localparam int unsigned NS = 3;
  localparam int unsigned TO = 255;
  localparam int unsigned QW = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  codec_stage_seq_if #(.NUM_STAGES(NS), .QW(QW)) bus ();

  codec_stage_seq #(.NUM_STAGES(NS), .TIMEOUT_CYC(TO), .QW(QW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // stub stages: sticky done k cycles after en (k=0: never), cleared by clr
  int              k_cfg   [NS];
  int              stub_cnt[NS];
  logic [NS-1:0]   stub_done, stub_run, stray;
  assign bus.stg_done = stub_done | stray;

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < int'(NS); i++) begin
      if (rst) begin
        stub_done[i] <= 1'b0;
        stub_run[i]  <= 1'b0;
        stub_cnt[i]  <= 0;
      end else if (bus.stg_clr[i]) begin
        stub_done[i] <= 1'b0;
        stub_run[i]  <= 1'b0;
      end else if (bus.stg_en[i]) begin
        stub_run[i]  <= 1'b1;
        stub_cnt[i]  <= 1;
      end else if (stub_run[i]) begin
        if (k_cfg[i] != 0 && stub_cnt[i] == k_cfg[i] - 1) begin
          stub_done[i] <= 1'b1;
          stub_run[i]  <= 1'b0;
        end else begin
          stub_cnt[i] <= stub_cnt[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int oh_idx(input logic [NS-1:0] v);
    for (int i = 0; i < int'(NS); i++) if (v[i]) return i;
    return -1;
  endfunction

  // pulse logs and one-hot / exclusivity monitor
  int en_log[$];
  int clr_log[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.stg_en  != '0) en_log.push_back(oh_idx(bus.stg_en));
      if (bus.stg_clr != '0) clr_log.push_back(oh_idx(bus.stg_clr));
      chk("pulse_onehot_excl",
          int'(!(bus.stg_en != '0 && bus.stg_clr != '0) &&
               (bus.stg_en  == '0 || $onehot(bus.stg_en)) &&
               (bus.stg_clr == '0 || $onehot(bus.stg_clr))), 1);
    end
  end

  typedef struct {
    int q;
    int k0, k1, k2;
    int mask;
    int exp_q, exp_err, exp_cur, exp_lat, exp_en;
  } vec_t;

  function automatic vec_t mk(int q, int k0, int k1, int k2, int mask,
                              int eq, int ee, int ec, int el, int een);
    vec_t v;
    v.q = q; v.k0 = k0; v.k1 = k1; v.k2 = k2; v.mask = mask;
    v.exp_q = eq; v.exp_err = ee; v.exp_cur = ec; v.exp_lat = el; v.exp_en = een;
    return v;
  endfunction

  task automatic wait_ready(input string tag);
    int t = 0;
    while (!bus.in_ready && t < 50) begin @(negedge clk); t++; end
    chk({tag, " in_ready"}, int'(bus.in_ready), 1);
  endtask

  task automatic check_log(input string tag, input int exp_mask);
    int exp_q[$];
    for (int i = 0; i < int'(NS); i++) if (exp_mask[i]) exp_q.push_back(i);
    chk({tag, " en_count"},  en_log.size(),  exp_q.size());
    chk({tag, " clr_count"}, clr_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < en_log.size())  chk($sformatf("%s en[%0d]", tag, i),  en_log[i],  exp_q[i]);
      if (i < clr_log.size()) chk($sformatf("%s clr[%0d]", tag, i), clr_log[i], exp_q[i]);
    end
  endtask

  // one block: accept, stray done[2] early, q_in change, 20-cycle sink stall
  task automatic run_block(input vec_t v, input string tag);
    int acc;
    k_cfg[0] = v.k0; k_cfg[1] = v.k1; k_cfg[2] = v.k2;
    wait_ready(tag);
    en_log.delete();
    clr_log.delete();
    bus.q_in     = QW'(v.q);
    bus.in_valid = 1'b1;
`ifdef STAGE_BYPASS_EN
    bus.bypass_mask = NS'(v.mask);
`endif
    acc = cyc;
    @(negedge clk);
    bus.q_in = QW'(10);
    stray    = 3'b100;
    while (!bus.out_valid && (cyc - acc) < 1000) begin
      @(negedge clk);
      if (cyc - acc >= 4) stray = '0;
    end
    stray = '0;
    chk({tag, " latency"}, cyc - acc, v.exp_lat);
    chk({tag, " err"},  int'(bus.err),       v.exp_err);
    chk({tag, " cur"},  int'(bus.cur_stage), v.exp_cur);
    chk({tag, " qout"}, int'(bus.q_out),     v.exp_q);
    check_log(tag, v.exp_en);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk({tag, " stall out_valid"}, int'(bus.out_valid), 1);
      chk({tag, " stall err"},       int'(bus.err),       v.exp_err);
      chk({tag, " stall in_ready"},  int'(bus.in_ready),  0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, " done out_valid"}, int'(bus.out_valid), 0);
    chk({tag, " done in_ready"},  int'(bus.in_ready),  1);
    chk({tag, " done busy"},      int'(bus.busy),      0);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, " in_ready"},  int'(bus.in_ready),  0);
    chk({tag, " out_valid"}, int'(bus.out_valid), 0);
    chk({tag, " busy"},      int'(bus.busy),      0);
    chk({tag, " err"},       int'(bus.err),       0);
    chk({tag, " q_out"},     int'(bus.q_out),     0);
    chk({tag, " cur"},       int'(bus.cur_stage), 0);
    chk({tag, " stg_en"},    int'(bus.stg_en),    0);
    chk({tag, " stg_clr"},   int'(bus.stg_clr),   0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[$];

  initial begin
    int t;
    // latency = sum(k_i + 3) + 1; timeout stage: 2 + 255 WAIT cycles
    vecs.push_back(mk( 50, 66,  66, 66, 0,  50, 0, 2, 208, 7));
    vecs.push_back(mk(  0,  2,   2,  2, 0,   1, 0, 2,  16, 7));
    vecs.push_back(mk(120,  5,   3,  2, 0, 100, 0, 2,  20, 7));
    vecs.push_back(mk(100,  2, 255,  2, 0, 100, 0, 2, 269, 7));
    vecs.push_back(mk(  1, 66,   0, 66, 0,   1, 1, 1, 327, 3));
    vecs.push_back(mk(127,  2,   2,  2, 0, 100, 0, 2,  16, 7));
`ifdef STAGE_BYPASS_EN
    vecs.push_back(mk( 60,  2,   2,  2, 2,  60, 0, 2,  11, 5));
    vecs.push_back(mk( 60,  2,   2,  2, 7,  60, 0, 0,   2, 0));
`endif

    rst = 1'b0;
    bus.in_valid = 1'b0; bus.q_in = '0; bus.out_ready = 1'b0;
    stray = '0;
    for (int i = 0; i < int'(NS); i++) k_cfg[i] = 2;
`ifdef STAGE_BYPASS_EN
    bus.bypass_mask = '0;
`endif
    #1 rst = 1'b1;
    #1 check_reset_outs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset in_ready", int'(bus.in_ready), 1);
    chk("post_reset busy",     int'(bus.busy),     0);

    for (int i = 0; i < vecs.size(); i++) run_block(vecs[i], $sformatf("vec%0d", i));

    // reset in the middle of stage 1 WAIT
    for (int i = 0; i < int'(NS); i++) k_cfg[i] = 66;
    wait_ready("midrst");
    en_log.delete(); clr_log.delete();
    bus.q_in = QW'(30); bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    t = 0;
    while (en_log.size() < 2 && t < 500) begin @(negedge clk); t++; end
    chk("midrst reached stage1", en_log.size(), 2);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1 check_reset_outs("midrst");
    @(negedge clk);
    check_reset_outs("midrst hold");
    rst = 1'b0;
    @(negedge clk);
    chk("midrst in_ready", int'(bus.in_ready), 1);
    chk("midrst busy",     int'(bus.busy),     0);
    run_block(vecs[1], "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
